// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_edge block.
package debounce_pkg;

  typedef enum logic {ST_STABLE, ST_CHECK} debounce_state_t;

  localparam int unsigned DEB_STABLE_CYCLES_DEF = 16;
  localparam int unsigned DEB_HOLD_CYCLES_DEF   = 1000;
  localparam int unsigned DEB_REPEAT_CYCLES_DEF = 250;

  function automatic int unsigned deb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_hold_timer.sv
// Long-press / auto-repeat timer: one hold strobe HOLD_CYCLES after start, then every
// REPEAT_CYCLES while run stays high. stop clears the timer and suppresses a same-cycle strobe.
module debounce_hold_timer
  import debounce_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEB_HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = DEB_REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic stop,
  output logic hold
);

  localparam int unsigned TW = $clog2(deb_max(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_inc;
  logic          rep_q;
  logic          hold_q;

  assign cnt_inc = cnt_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rep_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (stop || start || !run) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else if ((!rep_q && cnt_inc == TW'(HOLD_CYCLES)) ||
                   ( rep_q && cnt_inc == TW'(REPEAT_CYCLES))) begin
        hold_q <= 1'b1;
        cnt_q  <= '0;
        rep_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign hold = hold_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer for a pre-synchronized input: clean level plus one-cycle rise/fall strobes.
// Optional long-press/auto-repeat hold strobe when DEBOUNCE_HOLD_EN is defined.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
  parameter logic        INIT_LEVEL    = 1'b0,
  parameter int unsigned HOLD_CYCLES   = DEB_HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = DEB_REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_sync,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("debounce_edge: HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("debounce_edge: REPEAT_CYCLES must be >= 2");
  end

  debounce_state_t state_q;
  logic [CW-1:0]   cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;
  logic            toggle;

  // Final qualifying sample of a run: level flips on this edge.
  assign toggle = (state_q == ST_CHECK) && (d_sync != level_q) &&
                  (cnt_q == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (d_sync != level_q) begin
            state_q <= ST_CHECK;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_CHECK: begin
          if (d_sync == level_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (toggle) begin
            level_q <= ~level_q;
            rise_q  <= ~level_q;
            fall_q  <= level_q;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef DEBOUNCE_HOLD_EN
  // Timer is fed next-cycle strobes so a hold coinciding with fall is dropped.
  logic start_nx;
  logic stop_nx;
  logic run_nx;

  assign start_nx = toggle & ~level_q;
  assign stop_nx  = toggle & level_q;
  assign run_nx   = level_q ^ toggle;

  debounce_hold_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_nx),
    .run  (run_nx),
    .stop (stop_nx),
    .hold (hold)
  );
`else
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed vector table, corner sequences, random vs model.
module tb_debounce_edge;

  localparam int SC = 4;
  localparam int HC = 10;
  localparam int RC = 5;
`ifdef DEBOUNCE_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic d_sync;
  logic level, rise, fall, hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_edge #(
    .STABLE_CYCLES(SC),
    .INIT_LEVEL   (1'b0),
    .HOLD_CYCLES  (HC),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_sync(d_sync),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .hold  (hold)
  );

  typedef struct {
    logic d;
    logic lvl;
    logic r;
    logic f;
    logic h;
  } vec_t;

  vec_t vecs[$];

  // Reference model: run length of samples disagreeing with the level, and age since rise.
  logic m_level;
  int   m_run;
  int   m_age;
  logic e_rise, e_fall, e_hold;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic r, input logic f,
                         input logic h);
    chk({tag, ".level"}, level, l);
    chk({tag, ".rise"},  rise,  r);
    chk({tag, ".fall"},  fall,  f);
    chk({tag, ".hold"},  hold,  h);
  endtask

  task automatic model_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_age   = 0;
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    e_hold  = 1'b0;
  endtask

  task automatic model_edge(input logic d);
    e_rise = 1'b0;
    e_fall = 1'b0;
    e_hold = 1'b0;
    if (d != m_level) m_run++;
    else m_run = 0;
    if (m_run == SC) begin
      m_level = ~m_level;
      m_run   = 0;
      if (m_level) begin
        e_rise = 1'b1;
        m_age  = 0;
      end else begin
        e_fall = 1'b1;
      end
    end else if (m_level) begin
      m_age++;
      if (HOLD_EN && m_age >= HC && ((m_age - HC) % RC) == 0) e_hold = 1'b1;
    end
  endtask

  task automatic step(input logic d);
    d_sync = d;
    @(posedge clk);
    model_edge(d);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    d_sync = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic d, input logic l, input logic r, input logic f,
                         input logic h);
    vec_t v;
    v.d = d; v.lvl = l; v.r = r; v.f = f; v.h = h;
    vecs.push_back(v);
  endtask

  initial begin
    // Glitch, press (rise at R), release with a hold strobe at R+10, fall at R+12, chatter.
    for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, HOLD_EN);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) add_vec(logic'(i % 2 == 0), 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, visible before the first clock edge.
    rst_n  = 1'b0;
    d_sync = 1'b0;
    model_reset();
    #2;
    chk_all("reset_init", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].r, vecs[i].f, vecs[i].h);
    end

    // Asynchronous reset from level=1 at a random point inside the cycle.
    for (int k = 1; k <= SC; k++) step(1'b1);
    chk("async_pre.level", level, 1'b1);
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    #1;
    chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();

    // Reset mid-CHECK discards the partial count.
    step(1'b1);
    chk("midchk1.level", level, 1'b0);
    step(1'b1);
    chk("midchk2.level", level, 1'b0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= SC; k++) begin
      step(1'b1);
      chk_all($sformatf("midchk_post%0d", k), logic'(k == SC), logic'(k == SC), 1'b0, 1'b0);
    end
    step(1'b1);
    chk_all("midchk_after", 1'b1, 1'b0, 1'b0, 1'b0);

    // Long press: held 30 edges; the hold due at R+30 coincides with fall and is dropped.
    apply_reset();
    for (int k = 1; k <= SC; k++) begin
      step(1'b1);
      chk_all($sformatf("hold_press%0d", k), logic'(k == SC), logic'(k == SC), 1'b0, 1'b0);
    end
    for (int j = 1; j <= 30; j++) begin
      step(logic'(j <= 26));
      chk_all($sformatf("hold_R+%0d", j), logic'(j < 30), 1'b0, logic'(j == 30),
              HOLD_EN && (j == 10 || j == 15 || j == 20 || j == 25));
    end
    for (int j = 31; j <= 36; j++) begin
      step(1'b0);
      chk_all($sformatf("hold_R+%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random runs against the reference model.
    apply_reset();
    for (int blk = 0; blk < 200; blk++) begin
      logic v;
      int   len;
      v   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, (blk % 5 == 0) ? 28 : 6);
      for (int k = 0; k < len; k++) begin
        step(v);
        chk_all("rand", m_level, e_rise, e_fall, e_hold);
        chk("rand.excl", rise & fall, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
